// File: rtl/rpn_exec.sv
`default_nettype none
// ============================================================================
//  Module      : rpn_exec
//  Description : Stack-based byte-code executor fed by a 5-byte instruction
//                queue. Decodes one 1- or 2-byte instruction per cycle from
//                the queue head window. Executes 8-bit RPN arithmetic on a
//                small operand stack. Emits OUT values through a one-cycle
//                valid strobe. Holds a sticky error state until reset.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                win[15:0]           - queue head (win[15:8] opcode, [7:0] next)
//                win_valid, win_two  - one / two head bytes valid
//                take, take2         - retire request (1 or 2 bytes), comb.
//                result, result_valid- last OUT value and its strobe
//                err, err_code       - sticky error flag and cause
//                depth               - current stack occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module rpn_exec #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] win,
    input  logic        win_valid,
    input  logic        win_two,
    output logic        take,
    output logic        take2,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  depth
);

    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_mul   = 2'd1;
    localparam logic [1:0] c_st_err   = 2'd2;

    localparam logic [7:0] c_op_nop  = 8'h00;
    localparam logic [7:0] c_op_push = 8'h01;
    localparam logic [7:0] c_op_add  = 8'h02;
    localparam logic [7:0] c_op_sub  = 8'h03;
    localparam logic [7:0] c_op_and  = 8'h04;
    localparam logic [7:0] c_op_or   = 8'h05;
    localparam logic [7:0] c_op_xor  = 8'h06;
    localparam logic [7:0] c_op_mul  = 8'h07;
    localparam logic [7:0] c_op_out  = 8'h08;
    localparam logic [7:0] c_op_dup  = 8'h09;

    localparam logic [1:0] c_code_illegal   = 2'd1;
    localparam logic [1:0] c_code_underflow = 2'd2;
    localparam logic [1:0] c_code_overflow  = 2'd3;

    localparam logic [2:0] c_depth_max = 3'(DEPTH);

    logic [1:0] r_state;
    logic [2:0] r_depth;
    logic [7:0] r_stk [DEPTH];
    logic [7:0] r_result;
    logic       r_result_valid;
    logic [1:0] r_err_code;
    logic [7:0] r_mcand;
    logic [7:0] r_mplier;
    logic [7:0] r_acc;
    logic [2:0] r_mul_cnt;

    logic [7:0] w_op;
    logic [7:0] w_imm;
    logic [7:0] w_top;
    logic [7:0] w_nxt;
    logic [7:0] w_alu;
    logic [7:0] w_acc_nxt;
    logic       w_take;
    logic       w_take2;
    logic [1:0] w_code;
    logic       w_err_set;
    logic       w_wr_en;
    logic [2:0] w_wr_idx;
    logic [7:0] w_wr_data;
    logic [2:0] w_depth_nxt;
    logic [1:0] w_state_nxt;
    logic       w_out_fire;
    logic       w_mul_start;

    assign w_op  = win[15:8];
    assign w_imm = win[7:0];

    // Top-of-stack (b) and next-of-stack (a) read ports. Compare-based
    // selection keeps the index width independent of DEPTH.
    always_comb begin
        w_top = '0;
        w_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) == r_depth - 3'd1) w_top = r_stk[i];
            if (3'(i) == r_depth - 3'd2) w_nxt = r_stk[i];
        end
    end

    always_comb begin
        case (w_op)
            c_op_add: w_alu = w_nxt + w_top;
            c_op_sub: w_alu = w_nxt - w_top;
            c_op_and: w_alu = w_nxt & w_top;
            c_op_or:  w_alu = w_nxt | w_top;
            c_op_xor: w_alu = w_nxt ^ w_top;
            default:  w_alu = '0;
        endcase
    end

    // Shift-add step: the product on the last step is this value.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 8'h00);

    // Decode / next-state. The stack has a single write port: PUSH and DUP
    // write at depth, binary ops and MUL completion overwrite depth-2.
    always_comb begin
        w_take      = 1'b0;
        w_take2     = 1'b0;
        w_code      = 2'd0;
        w_err_set   = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = '0;
        w_wr_data   = '0;
        w_depth_nxt = r_depth;
        w_state_nxt = r_state;
        w_out_fire  = 1'b0;
        w_mul_start = 1'b0;

        case (r_state)
            c_st_fetch: begin
                if (win_valid && !(w_op == c_op_push && !win_two)) begin
                    w_take  = 1'b1;
                    w_take2 = (w_op == c_op_push);

                    if (w_op > c_op_dup)
                        w_code = c_code_illegal;
                    else if (w_op >= c_op_add && w_op <= c_op_mul && r_depth < 3'd2)
                        w_code = c_code_underflow;
                    else if ((w_op == c_op_out || w_op == c_op_dup) && r_depth == 3'd0)
                        w_code = c_code_underflow;
                    else if ((w_op == c_op_push || w_op == c_op_dup) && r_depth == c_depth_max)
                        w_code = c_code_overflow;

                    if (w_code != 2'd0) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = c_st_err;
                    end else begin
                        case (w_op)
                            c_op_push: begin
                                w_wr_en     = 1'b1;
                                w_wr_idx    = r_depth;
                                w_wr_data   = w_imm;
                                w_depth_nxt = r_depth + 3'd1;
                            end
                            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor: begin
                                w_wr_en     = 1'b1;
                                w_wr_idx    = r_depth - 3'd2;
                                w_wr_data   = w_alu;
                                w_depth_nxt = r_depth - 3'd1;
                            end
                            c_op_mul: begin
                                w_mul_start = 1'b1;
                                w_state_nxt = c_st_mul;
                            end
                            c_op_out: begin
                                w_out_fire  = 1'b1;
                                w_depth_nxt = r_depth - 3'd1;
                            end
                            c_op_dup: begin
                                w_wr_en     = 1'b1;
                                w_wr_idx    = r_depth;
                                w_wr_data   = w_top;
                                w_depth_nxt = r_depth + 3'd1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            c_st_mul: begin
                // Operands stay on the stack during the multiply so depth
                // reads the pre-MUL value until the product replaces them.
                if (r_mul_cnt == 3'd7) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = r_depth - 3'd2;
                    w_wr_data   = w_acc_nxt;
                    w_depth_nxt = r_depth - 3'd1;
                    w_state_nxt = c_st_fetch;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_fetch;
            r_depth        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err_code     <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_acc          <= '0;
            r_mul_cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_depth        <= w_depth_nxt;
            r_result_valid <= w_out_fire;
            if (w_out_fire) r_result <= w_top;
            if (w_err_set) r_err_code <= w_code;
            if (w_wr_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (3'(i) == w_wr_idx) r_stk[i] <= w_wr_data;
                end
            end
            if (w_mul_start) begin
                r_mcand   <= w_nxt;
                r_mplier  <= w_top;
                r_acc     <= '0;
                r_mul_cnt <= '0;
            end else if (r_state == c_st_mul) begin
                r_acc     <= w_acc_nxt;
                r_mcand   <= {r_mcand[6:0], 1'b0};
                r_mplier  <= {1'b0, r_mplier[7:1]};
                r_mul_cnt <= r_mul_cnt + 3'd1;
            end
        end
    end

    // The queue must not retire anything on a reset edge.
    assign take         = w_take & ~rst;
    assign take2        = w_take2 & ~rst;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign err          = (r_state == c_st_err);
    assign err_code     = r_err_code;
    assign depth        = r_depth;

endmodule
`default_nettype wire
